// File: rtl/xy_scene_scheduler.sv
// xy_scene_scheduler: round-robin frame-granular sharing of the X/Y DAC pair between two shape generators
module xy_scene_scheduler #(
  parameter logic [23:0] MAX_DWELL = 24'd10_000_000,
  parameter logic [7:0] SETTLE_CYCLES = 8'd16,
  parameter logic [7:0] CENTER = 8'h80
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] frame_done,
  input  logic [7:0] x0,
  input  logic [7:0] y0,
  input  logic [7:0] x1,
  input  logic [7:0] y1,
  output logic [1:0] grant,
  output logic [7:0] xdac,
  output logic [7:0] ydac,
  output logic       blank,
  output logic       timeout
);
  typedef enum logic [1:0] {IDLE, SETTLE, SERVE} state_t;
  state_t r_state, w_state;
  logic r_sel, w_sel, r_last, w_last, r_blank, w_blank, r_timeout, w_timeout;
  logic [1:0] r_grant, w_grant;
  logic [7:0] r_xdac, w_xdac, r_ydac, w_ydac, r_settle, w_settle;
  logic [23:0] r_dwell, w_dwell;
  logic w_pick, w_req_sel, w_req_oth, w_fd, w_to;
  assign w_pick = req[0] ? (req[1] ? !r_last : 1'b0) : 1'b1;
  assign w_req_sel = req[r_sel];
  assign w_req_oth = req[!r_sel];
  assign w_fd = frame_done[r_sel];
  assign w_to = r_dwell == MAX_DWELL - 24'd1;
  always_comb begin
    w_state = r_state;
    w_sel = r_sel;
    w_last = r_last;
    w_grant = r_grant;
    w_blank = r_blank;
    w_timeout = 1'b0;
    w_dwell = r_dwell;
    w_settle = r_settle;
    w_xdac = r_sel ? x1 : x0;
    w_ydac = r_sel ? y1 : y0;
    case (r_state)
      IDLE: begin
        w_xdac = CENTER;
        w_ydac = CENTER;
        w_blank = 1'b1;
        if (|req) begin
          w_sel = w_pick;
          w_grant = w_pick ? 2'b10 : 2'b01;
          w_settle = 8'd0;
          w_state = SETTLE;
        end
      end
      SETTLE: begin
        w_settle = r_settle + 8'd1;
        if (!w_req_sel) begin
          w_state = IDLE;
          w_grant = 2'b00;
          w_xdac = CENTER;
          w_ydac = CENTER;
          w_blank = 1'b1;
        end else if (r_settle == SETTLE_CYCLES - 8'd1) begin
          w_state = SERVE;
          w_blank = 1'b0;
          w_dwell = 24'd0;
        end
      end
      SERVE: begin
        w_dwell = r_dwell + 24'd1;
        if (!w_req_sel) begin
          w_state = IDLE;
          w_grant = 2'b00;
          w_last = r_sel;
          w_xdac = CENTER;
          w_ydac = CENTER;
          w_blank = 1'b1;
        end else begin
          w_timeout = w_to;
          if (w_fd || w_to) begin
            if (w_req_oth) begin
              w_state = SETTLE;
              w_last = r_sel;
              w_sel = !r_sel;
              w_grant = r_sel ? 2'b01 : 2'b10;
              w_settle = 8'd0;
              w_blank = 1'b1;
            end else
              w_dwell = 24'd0;
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_sel <= 1'b0;
      r_last <= 1'b1;
      r_grant <= 2'b00;
      r_blank <= 1'b1;
      r_timeout <= 1'b0;
      r_dwell <= 24'd0;
      r_settle <= 8'd0;
      r_xdac <= CENTER;
      r_ydac <= CENTER;
    end else begin
      r_state <= w_state;
      r_sel <= w_sel;
      r_last <= w_last;
      r_grant <= w_grant;
      r_blank <= w_blank;
      r_timeout <= w_timeout;
      r_dwell <= w_dwell;
      r_settle <= w_settle;
      r_xdac <= w_xdac;
      r_ydac <= w_ydac;
    end
  end
  assign grant = r_grant;
  assign xdac = r_xdac;
  assign ydac = r_ydac;
  assign blank = r_blank;
  assign timeout = r_timeout;
endmodule

// File: tb/tb_xy_scene_scheduler.sv
// tb_xy_scene_scheduler: directed stimulus with a cycle-stamped expectation queue checked by an independent monitor
module tb_xy_scene_scheduler;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] req, frame_done, grant;
  logic [7:0] x0, y0, x1, y1, xdac, ydac;
  logic blank, timeout;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  typedef struct {
    int when;
    string name;
    logic [1:0] g;
    logic b;
    logic t;
    bit cxy;
    logic [7:0] x;
    logic [7:0] y;
  } exp_t;
  exp_t q[$];
  exp_t e;
  xy_scene_scheduler #(.MAX_DWELL(24'd100), .SETTLE_CYCLES(8'd16), .CENTER(8'h80)) dut (
    .clk(clk), .reset(reset), .req(req), .frame_done(frame_done),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .grant(grant), .xdac(xdac), .ydac(ydac), .blank(blank), .timeout(timeout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].when <= cyc) begin
      e = q.pop_front();
      n_checks++;
      if (grant !== e.g || blank !== e.b || timeout !== e.t || (e.cxy && (xdac !== e.x || ydac !== e.y))) begin
        n_fail++;
        $display("FAIL %s cyc=%0d got grant=%b blank=%b timeout=%b x=%h y=%h want grant=%b blank=%b timeout=%b x=%h y=%h (xy checked=%0d)",
                 e.name, cyc, grant, blank, timeout, xdac, ydac, e.g, e.b, e.t, e.x, e.y, e.cxy);
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic expect_at(input int dt, input string nm, input logic [1:0] g, input logic b, input logic t,
                           input bit cxy, input logic [7:0] x, input logic [7:0] y);
    exp_t r;
    r.when = cyc + dt;
    r.name = nm;
    r.g = g;
    r.b = b;
    r.t = t;
    r.cxy = cxy;
    r.x = x;
    r.y = y;
    q.push_back(r);
  endtask
  initial begin
    reset = 1'b1;
    req = 2'b00;
    frame_done = 2'b00;
    x0 = 8'h10;
    y0 = 8'h20;
    x1 = 8'h30;
    y1 = 8'h40;
    step(2);
    expect_at(0, "reset", 2'b00, 1'b1, 1'b0, 1, 8'h80, 8'h80);
    reset = 1'b0;
    req = 2'b01;
    expect_at(1, "t2_grant", 2'b01, 1'b1, 1'b0, 1, 8'h80, 8'h80);
    expect_at(2, "t2_track", 2'b01, 1'b1, 1'b0, 1, 8'h10, 8'h20);
    expect_at(16, "t2_settle_end", 2'b01, 1'b1, 1'b0, 1, 8'h10, 8'h20);
    expect_at(17, "t2_serve", 2'b01, 1'b0, 1'b0, 1, 8'h10, 8'h20);
    step(17);
    x0 = 8'h11;
    expect_at(1, "t2_latency", 2'b01, 1'b0, 1'b0, 1, 8'h11, 8'h20);
    step(1);
    req = 2'b11;
    frame_done = 2'b01;
    expect_at(1, "t3_switch", 2'b10, 1'b1, 1'b0, 1, 8'h11, 8'h20);
    step(1);
    frame_done = 2'b00;
    expect_at(1, "t3_track1", 2'b10, 1'b1, 1'b0, 1, 8'h30, 8'h40);
    expect_at(15, "t3_settle_end", 2'b10, 1'b1, 1'b0, 0, 8'h00, 8'h00);
    expect_at(16, "t3_serve1", 2'b10, 1'b0, 1'b0, 1, 8'h30, 8'h40);
    step(16);
    frame_done = 2'b01;
    expect_at(1, "t3_foreign_fd", 2'b10, 1'b0, 1'b0, 1, 8'h30, 8'h40);
    step(1);
    frame_done = 2'b10;
    expect_at(1, "t3_back_to_0", 2'b01, 1'b1, 1'b0, 1, 8'h30, 8'h40);
    step(1);
    frame_done = 2'b00;
    expect_at(16, "t4_serve0", 2'b01, 1'b0, 1'b0, 0, 8'h00, 8'h00);
    expect_at(115, "t4_pre_timeout", 2'b01, 1'b0, 1'b0, 1, 8'h11, 8'h20);
    expect_at(116, "t4_timeout_switch", 2'b10, 1'b1, 1'b1, 1, 8'h11, 8'h20);
    expect_at(117, "t4_timeout_over", 2'b10, 1'b1, 1'b0, 1, 8'h30, 8'h40);
    step(117);
    req = 2'b01;
    expect_at(1, "t4_settle_drop", 2'b00, 1'b1, 1'b0, 1, 8'h80, 8'h80);
    expect_at(2, "t4_regrant0", 2'b01, 1'b1, 1'b0, 1, 8'h80, 8'h80);
    expect_at(18, "t4_serve_solo", 2'b01, 1'b0, 1'b0, 0, 8'h00, 8'h00);
    expect_at(117, "t4_solo_pre", 2'b01, 1'b0, 1'b0, 0, 8'h00, 8'h00);
    expect_at(118, "t4_solo_pulse1", 2'b01, 1'b0, 1'b1, 1, 8'h11, 8'h20);
    expect_at(119, "t4_solo_post1", 2'b01, 1'b0, 1'b0, 0, 8'h00, 8'h00);
    expect_at(217, "t4_solo_pre2", 2'b01, 1'b0, 1'b0, 0, 8'h00, 8'h00);
    expect_at(218, "t4_solo_pulse2", 2'b01, 1'b0, 1'b1, 1, 8'h11, 8'h20);
    step(218);
    req = 2'b00;
    expect_at(1, "t5_drop", 2'b00, 1'b1, 1'b0, 1, 8'h80, 8'h80);
    step(1);
    frame_done = 2'b10;
    expect_at(1, "t5_stray_fd", 2'b00, 1'b1, 1'b0, 1, 8'h80, 8'h80);
    step(1);
    frame_done = 2'b00;
    req = 2'b11;
    expect_at(1, "t6_rr_pick1", 2'b10, 1'b1, 1'b0, 1, 8'h80, 8'h80);
    step(6);
    reset = 1'b1;
    expect_at(1, "t6_reset_mid_settle", 2'b00, 1'b1, 1'b0, 1, 8'h80, 8'h80);
    step(1);
    reset = 1'b0;
    expect_at(1, "t6_rearb0", 2'b01, 1'b1, 1'b0, 1, 8'h80, 8'h80);
    expect_at(2, "t6_track0", 2'b01, 1'b1, 1'b0, 1, 8'h11, 8'h20);
    expect_at(16, "t6_settle_end", 2'b01, 1'b1, 1'b0, 0, 8'h00, 8'h00);
    expect_at(17, "t6_serve", 2'b01, 1'b0, 1'b0, 1, 8'h11, 8'h20);
    step(17);
    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end
endmodule
